// File: rtl/poly1305_block_framer_if.sv
// Block-stream bus between the source data path, the framer and the
// Poly1305 MAC adapter: one source channel in, AAD/payload/length channels out.
interface poly1305_block_framer_if;
  logic         src_valid;
  logic [127:0] src_data;
  logic         src_ready;

  logic         aad_valid;
  logic [127:0] aad_data;
  logic [15:0]  aad_keep;
  logic         aad_ready;

  logic         pld_valid;
  logic [127:0] pld_data;
  logic [15:0]  pld_keep;
  logic         pld_ready;

  logic         len_valid;
  logic [127:0] len_block;
  logic         len_ready;

  // Framer side
  modport master (
    input  src_valid, src_data,
    output src_ready,
    output aad_valid, aad_data, aad_keep,
    input  aad_ready,
    output pld_valid, pld_data, pld_keep,
    input  pld_ready,
    output len_valid, len_block,
    input  len_ready
  );

  // Source / sink side
  modport slave (
    output src_valid, src_data,
    input  src_ready,
    input  aad_valid, aad_data, aad_keep,
    output aad_ready,
    input  pld_valid, pld_data, pld_keep,
    output pld_ready,
    input  len_valid, len_block,
    output len_ready
  );
endinterface

// File: rtl/poly1305_block_framer.sv
// Poly1305 block framer: slices a byte-length-described message into AAD,
// payload and RFC 8439 length blocks with byte-keep masks and zero padding.
module poly1305_block_framer #(
  parameter int unsigned LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] aad_len_bytes,
  input  logic [LEN_W-1:0] pld_len_bytes,
  output logic             busy,
  output logic             done,
  poly1305_block_framer_if.master bus
);

  typedef enum logic [2:0] {IDLE, AAD, PLD, LEN, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] aad_len_q;
  logic [LEN_W-1:0] pld_len_q;

  // Single holding register shared by the AAD and payload channels
  logic             obuf_full;
  logic [127:0]     obuf_data;
  logic [15:0]      obuf_keep;

  logic             in_data_phase;
  logic             ch_ready;
  logic             consume;
  logic             accept;
  logic             rem_big;
  logic [4:0]       take;
  logic [15:0]      word_keep;
  logic [127:0]     word_data;

  // Source handshake and the framing of the incoming word
  always_comb begin
    in_data_phase = (state == AAD) || (state == PLD);
    ch_ready      = (state == AAD) ? bus.aad_ready : bus.pld_ready;
    consume       = in_data_phase && obuf_full && ch_ready;
    bus.src_ready = in_data_phase && (!obuf_full || ch_ready) && (rem != '0);
    accept        = bus.src_valid && bus.src_ready;
    rem_big       = |rem[LEN_W-1:4];
    take          = rem_big ? 5'd16 : {1'b0, rem[3:0]};
    word_keep     = '0;
    word_data     = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      word_keep[i] = (5'(i) < take);
      word_data[8*i +: 8] = word_keep[i] ? bus.src_data[8*i +: 8] : 8'h00;
    end
  end

  // Channel outputs: only the channel of the current phase sees the holding register
  always_comb begin
    bus.aad_valid = (state == AAD) && obuf_full;
    bus.aad_data  = bus.aad_valid ? obuf_data : '0;
    bus.aad_keep  = bus.aad_valid ? obuf_keep : '0;
    bus.pld_valid = (state == PLD) && obuf_full;
    bus.pld_data  = bus.pld_valid ? obuf_data : '0;
    bus.pld_keep  = bus.pld_valid ? obuf_keep : '0;
    bus.len_valid = (state == LEN);
    bus.len_block = (state == LEN) ? {64'(pld_len_q), 64'(aad_len_q)} : '0;
  end

  // Phase sequencing, byte counting and the holding register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      aad_len_q <= '0;
      pld_len_q <= '0;
      obuf_full <= 1'b0;
      obuf_data <= '0;
      obuf_keep <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            aad_len_q <= aad_len_bytes;
            pld_len_q <= pld_len_bytes;
            busy      <= 1'b1;
            if (aad_len_bytes != '0) begin
              state <= AAD;
              rem   <= aad_len_bytes;
            end else if (pld_len_bytes != '0) begin
              state <= PLD;
              rem   <= pld_len_bytes;
            end else begin
              state <= LEN;
              rem   <= '0;
            end
          end
        end
        AAD, PLD: begin
          if (accept) begin
            // Reload may coincide with consumption of the previous block
            obuf_full <= 1'b1;
            obuf_data <= word_data;
            obuf_keep <= word_keep;
            rem       <= rem - LEN_W'(take);
          end else if (consume) begin
            obuf_full <= 1'b0;
            if (rem == '0) begin
              if ((state == AAD) && (pld_len_q != '0)) begin
                state <= PLD;
                rem   <= pld_len_q;
              end else begin
                state <= LEN;
              end
            end
          end
        end
        LEN: begin
          if (bus.len_ready) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly1305_block_framer.sv
// Directed bench for poly1305_block_framer: whole messages with hand-chosen
// lengths, backpressure, mid-message reset and a stray start pulse.
module tb_poly1305_block_framer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] aad_len_bytes;
  logic [31:0] pld_len_bytes;
  logic        busy;
  logic        done;

  int unsigned n_cmp;
  int unsigned n_err;

  poly1305_block_framer_if bus ();

  poly1305_block_framer #(.LEN_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .aad_len_bytes (aad_len_bytes),
    .pld_len_bytes (pld_len_bytes),
    .busy          (busy),
    .done          (done),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Source word w: either all 0xFF or a byte pattern unique to the word
  function automatic logic [127:0] src_word(int unsigned w, bit ff);
    logic [127:0] d;
    for (int i = 0; i < 16; i++)
      d[8*i +: 8] = ff ? 8'hFF : 8'(w * 16 + i + 32'h31);
    return d;
  endfunction

  // Bytes carried by block j of a phase of len bytes
  function automatic int unsigned blk_bytes(int unsigned len, int unsigned j);
    if (len <= 16 * j) return 0;
    if (len - 16 * j >= 16) return 16;
    return len - 16 * j;
  endfunction

  function automatic logic [15:0] keep_of(int unsigned n);
    logic [15:0] k;
    for (int i = 0; i < 16; i++) k[i] = (i < n);
    return k;
  endfunction

  function automatic logic [127:0] pad_of(logic [127:0] d, int unsigned n);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = (i < n) ? d[8*i +: 8] : 8'h00;
    return r;
  endfunction

  task automatic run_msg(input string name, input int unsigned al, input int unsigned pl,
                         input bit ff, input int unsigned stall, input bit rst_mid,
                         input bit restart, input logic [127:0] exp_len);
    int unsigned idx, na, np, nl, nd, cyc, stall_left, xv, gaps, last_pld, exp_na, exp_np, nb;
    bit fin, aborted, hs_src, stalled_prev, restarted, do_rst;
    logic [127:0] held_d;
    logic [15:0]  held_k;
    idx = 0; na = 0; np = 0; nl = 0; nd = 0; cyc = 0; xv = 0; gaps = 0; last_pld = 0;
    fin = 0; aborted = 0; stalled_prev = 0; restarted = 0; do_rst = 0;
    held_d = '0; held_k = '0;
    stall_left = stall;
    exp_na = (al + 15) / 16;
    exp_np = (pl + 15) / 16;

    @(negedge clk);
    aad_len_bytes = al;
    pld_len_bytes = pl;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    aad_len_bytes = 32'h0000_DEAD;
    pld_len_bytes = 32'h0000_BEEF;
    check({name, "/busy_after_start"}, busy, 1'b1);

    while (!fin && cyc < 300) begin
      start = 1'b0;
      bus.src_valid = 1'b1;
      bus.src_data  = src_word(idx, ff);
      bus.aad_ready = 1'b1;
      bus.pld_ready = 1'b1;
      bus.len_ready = 1'b1;
      if (bus.aad_valid && stall_left > 0) begin
        bus.aad_ready = 1'b0;
        stall_left--;
      end
      #1;
      if (bus.aad_valid && bus.pld_valid) xv++;
      if (!bus.aad_valid && (bus.aad_data != '0 || bus.aad_keep != '0)) xv++;
      if (!bus.pld_valid && (bus.pld_data != '0 || bus.pld_keep != '0)) xv++;
      if (!bus.len_valid && bus.len_block != '0) xv++;

      if (stalled_prev && bus.aad_valid) begin
        check({name, "/stall_data"}, bus.aad_data, held_d);
        check({name, "/stall_keep"}, bus.aad_keep, held_k);
      end
      stalled_prev = bus.aad_valid && !bus.aad_ready;
      if (stalled_prev) begin
        held_d = bus.aad_data;
        held_k = bus.aad_keep;
        check({name, "/stall_src_ready"}, bus.src_ready, 1'b0);
      end

      if (bus.aad_valid && bus.aad_ready) begin
        nb = blk_bytes(al, na);
        check({name, "/aad_data"}, bus.aad_data, pad_of(src_word(na, ff), nb));
        check({name, "/aad_keep"}, bus.aad_keep, keep_of(nb));
        na++;
      end
      if (bus.pld_valid && bus.pld_ready) begin
        nb = blk_bytes(pl, np);
        check({name, "/pld_data"}, bus.pld_data, pad_of(src_word(exp_na + np, ff), nb));
        check({name, "/pld_keep"}, bus.pld_keep, keep_of(nb));
        if (np > 0 && cyc != last_pld + 1) gaps++;
        last_pld = cyc;
        np++;
        if (rst_mid) do_rst = 1;
      end
      if (bus.len_valid && bus.len_ready) begin
        check({name, "/len_block"}, bus.len_block, exp_len);
        nl++;
      end
      if (done) begin
        nd++;
        fin = 1;
        check({name, "/busy_at_done"}, busy, 1'b0);
      end
      if (restart && bus.pld_valid && !restarted) begin
        start = 1'b1;
        aad_len_bytes = 32'd7;
        pld_len_bytes = 32'd99;
        restarted = 1;
      end
      if (do_rst) rst_n = 1'b0;
      hs_src = bus.src_valid && bus.src_ready;
      @(posedge clk);
      if (hs_src) idx++;
      @(negedge clk);
      cyc++;
      if (do_rst) begin
        #1;
        check({name, "/rst_valids"},
              {bus.aad_valid, bus.pld_valid, bus.len_valid, bus.src_ready, busy, done}, '0);
        rst_n = 1'b1;
        fin = 1;
        aborted = 1;
      end
    end

    if (!aborted) begin
      check({name, "/finished"}, fin, 1'b1);
      check({name, "/aad_blocks"}, na, exp_na);
      check({name, "/pld_blocks"}, np, exp_np);
      check({name, "/len_blocks"}, nl, 1);
      check({name, "/done_pulses"}, nd, 1);
      check({name, "/pld_gaps"}, gaps, 0);
      check({name, "/idle_channels"}, xv, 0);
      @(negedge clk);
      check({name, "/done_one_cycle"}, done, 1'b0);
      check({name, "/busy_after"}, busy, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    aad_len_bytes = '0;
    pld_len_bytes = '0;
    bus.src_valid = 1'b1;
    bus.src_data  = '1;
    bus.aad_ready = 1'b1;
    bus.pld_ready = 1'b1;
    bus.len_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset/valids", {bus.aad_valid, bus.pld_valid, bus.len_valid}, 3'b000);
    check("reset/src_ready", bus.src_ready, 1'b0);
    check("reset/busy_done", {busy, done}, 2'b00);
    check("reset/outputs",
          bus.aad_data | bus.pld_data | bus.len_block | {bus.aad_keep, bus.pld_keep}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("idle/src_ready", bus.src_ready, 1'b0);

    run_msg("full_blocks", 16, 32, 1'b0, 0, 1'b0, 1'b0,
            128'h00000000_00000020_00000000_00000010);
    run_msg("partial", 5, 17, 1'b1, 0, 1'b0, 1'b0,
            128'h00000000_00000011_00000000_00000005);
    run_msg("empty", 0, 0, 1'b0, 0, 1'b0, 1'b0, 128'h0);
    run_msg("backpressure", 32, 20, 1'b0, 3, 1'b0, 1'b0,
            128'h00000000_00000014_00000000_00000020);
    run_msg("reset_mid", 16, 48, 1'b0, 0, 1'b1, 1'b0,
            128'h00000000_00000030_00000000_00000010);
    run_msg("after_reset", 20, 3, 1'b0, 0, 1'b0, 1'b0,
            128'h00000000_00000003_00000000_00000014);
    run_msg("restart_ignored", 16, 40, 1'b0, 0, 1'b0, 1'b1,
            128'h00000000_00000028_00000000_00000010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/poly1305_block_framer.md
Name: poly1305_block_framer

Overview:
- Producer end of the Poly1305 block-stream interface: turns a byte-length-described message into the AAD, payload and length block streams that the ChaCha20-Poly1305 MAC adapter consumes.
- Takes sequential 128-bit source words (AAD words first, then payload words) from the PIM data path.
- Emits each word on the matching channel with a byte-keep mask and zero padding on the last partial block.
- Closes the message with a single RFC 8439 length block.

Parameters:
LEN_W, 32, width of the AAD and payload byte-length inputs; each length is zero-extended to 64 bits in the length block.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  one-cycle pulse; latches lengths; ignored unless in IDLE
aad_len_bytes  input  LEN_W  AAD length in bytes
pld_len_bytes  input  LEN_W  payload length in bytes
src_valid  input  1  source word valid
src_data  input  128  source word; byte i at bits [8i+7:8i]
src_ready  output  1  framer accepts src_data this cycle
aad_valid  output  1  AAD block valid
aad_data  output  128  AAD block, padded
aad_keep  output  16  bit i set = byte i meaningful
aad_ready  input  1  sink accepts AAD block
pld_valid  output  1  payload block valid
pld_data  output  128  payload block, padded
pld_keep  output  16  byte mask
pld_ready  input  1  sink accepts payload block
len_valid  output  1  length block valid
len_block  output  128  {le64(pld_len), le64(aad_len)}: aad_len in [63:0], pld_len in [127:64]
len_ready  input  1  sink accepts length block
busy  output  1  high from the cycle after an accepted start until DONE
done  output  1  one-cycle pulse after the length block is accepted

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. All valid outputs, src_ready, busy and done are 0. All data, keep and len_block outputs are 0. Byte counters are cleared. Reset mid-operation abandons the message with no further outputs; any held block is dropped.
- States: IDLE, AAD, PLD, LEN, DONE.
- IDLE, start=1: latch both lengths into remaining-byte counters and set busy.
  - Next state is AAD if aad_len>0.
  - Otherwise PLD if pld_len>0.
  - Otherwise LEN.
- Output holding register (obuf) is shared by the AAD and payload channels. Only the channel of the current state ever drives valid=1; the other channel's valid, data and keep stay 0.
- Source handshake: src_ready=1 in AAD or PLD when (obuf empty OR current-channel ready=1) AND remaining>0. A word transfers when src_valid&&src_ready.
- Latency: source word accepted at edge t is valid on the channel after edge t; a valid block is visible in the cycle after its source word transfers. Throughput is 1 block/cycle under no backpressure.
- Framing per accepted word:
  - n = min(remaining,16); keep = (1<<n)-1; data bytes at index >= n are forced to 0.
  - remaining -= n.
- Holding rule: valid/data/keep are held stable until ready=1. A new word may load obuf in the same cycle the old one is consumed.
- Phase advance: when remaining reaches 0 and the last block of the phase is consumed, the state moves on.
  - AAD goes to PLD, or to LEN if pld_len=0.
  - PLD goes to LEN.
  - There is no cross-phase overlap: the first PLD word is not accepted until the last AAD block has transferred.
- LEN: len_valid=1 with len_block built from the latched lengths zero-extended to 64 bits; src_ready=0.
  - On len_ready, go to DONE.
  - done pulses in the cycle after the transfer; busy drops in that same cycle.
- DONE: returns to IDLE on the next clk; a start in DONE is ignored.
- start while busy is ignored; the latched lengths are unchanged.
- src_valid outside AAD/PLD is ignored (src_ready=0).
- Number of blocks per phase = ceil(len/16). A length of 0 produces no blocks on that channel.

Test Plan:
- aad=16, pld=32, all ready=1, no stalls:
  - one AAD block, keep=FFFF;
  - two PLD blocks, keep=FFFF, back-to-back;
  - len_block=128'h00000000_00000020_00000000_00000010;
  - done pulse.
- aad=5, pld=17, src bytes 0xFF:
  - AAD keep=001F, data bytes 5..15 = 0;
  - PLD blocks keep=FFFF then 0001, second block bytes 1..15 = 0.
- aad=0, pld=0:
  - no AAD/PLD valid;
  - len_valid with len_block=0;
  - done after len_ready.
- Backpressure: aad=32, hold aad_ready=0 for 3 cycles with the first block pending:
  - aad_data/aad_keep stable;
  - src_ready=0;
  - no word lost or duplicated.
- Reset mid-payload: assert rst_n=0 while pld_valid=1:
  - next cycle all valids 0, state IDLE;
  - a new start runs a full message correctly.
- start pulsed again during PLD with different lengths:
  - ignored;
  - len_block reflects the original lengths.
